// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and
// elaboration-time helpers for digit count and counter width.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Number of digits processed per operation.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit so N=1 still has a counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle for the digit-serial adder.
// Handshake: START is honoured on a rising edge only while BUSY=0 (IDLE or
// FIN); A/B/CIN/SUB are sampled on that same edge. BUSY stays high for the N
// computing cycles, then DONE pulses for one cycle while SUM/CARRY/OVF show
// the new result. There is no backpressure: the result must be taken on DONE.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    import digit_serial_adder_pkg::*;

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             CARRY;
    logic             OVF;
    state_t           STATE;  // debug view of the controller state

    modport master (
        output START, A, B, CIN, SUB,
        input  BUSY, DONE, SUM, CARRY, OVF, STATE
    );

    modport slave (
        input  START, A, B, CIN, SUB,
        output BUSY, DONE, SUM, CARRY, OVF, STATE
    );

endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// DIGIT-bit ripple chain of full-adder cells. Also exposes the carry into the
// top bit so the caller can form the two's-complement overflow flag.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic [DIGIT:0] c;

    assign c[0] = cin_i;

    for (genvar k = 0; k < DIGIT; k++) begin : g_fa
        assign sum_o[k] = a_i[k] ^ b_i[k] ^ c[k];
        assign c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
    end

    assign cout_o    = c[DIGIT];
    assign msb_cin_o = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock through one
// shared digit_adder, carrying between digits in a register. Subtraction is
// A + ~B + ~CIN, with the final carry inverted to report a borrow.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic           CLK,
    input logic           RST,
    digit_serial_adder_if.slave bus
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;      // operand A and effective B
    logic [WIDTH-1:0] res_q, res_d;  // internal, partially built result
    logic [WIDTH-1:0] sum_q;         // visible result, only updated on FIN entry
    logic [CW-1:0]    cnt_q;
    logic             carry_q, sub_q, cout_q, ovf_q, busy_q, done_q;

    int               digit_base;
    logic [DIGIT-1:0] a_dig, b_dig, dsum;
    logic             dcout, dmsb;

    assign digit_base = int'(cnt_q) * DIGIT;

    // Select the current digit of each operand and merge its sum into the result.
    always_comb begin
        a_dig = a_q[digit_base +: DIGIT];
        b_dig = b_q[digit_base +: DIGIT];
        res_d = res_q;
        res_d[digit_base +: DIGIT] = dsum;
    end

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i       (a_dig),
        .b_i       (b_dig),
        .cin_i     (carry_q),
        .sum_o     (dsum),
        .cout_o    (dcout),
        .msb_cin_o (dmsb)
    );

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= ST_IDLE;
                    if (bus.START) begin
                        a_q     <= bus.A;
                        b_q     <= bus.SUB ? ~bus.B : bus.B;
                        carry_q <= bus.SUB ? ~bus.CIN : bus.CIN;
                        sub_q   <= bus.SUB;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_q   <= res_d;
                    carry_q <= dcout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= dcout ^ sub_q;
                        ovf_q   <= dmsb ^ dcout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.SUM   = sum_q;
    assign bus.CARRY = cout_q;
    assign bus.OVF   = ovf_q;
    assign bus.STATE = state_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (16/4, 8/1, 8/8) share clock
// and reset. Drivers push expected {SUM,CARRY,OVF} into per-instance queues;
// negedge monitors pop and compare whenever DONE is seen.
module tb_digit_serial_adder;
    import digit_serial_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) if16 ();
    digit_serial_adder_if #(.WIDTH(8))  if81 ();
    digit_serial_adder_if #(.WIDTH(8))  if88 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.CLK(clk), .RST(rst), .bus(if16));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) dut81 (.CLK(clk), .RST(rst), .bus(if81));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) dut88 (.CLK(clk), .RST(rst), .bus(if88));

    // ---------------- scoreboard ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [17:0] exp16_q[$];
    logic [9:0]  exp81_q[$];
    logic [9:0]  exp88_q[$];
    logic [17:0] e16;
    logic [9:0]  e81, e88;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Independent reference: full-precision arithmetic plus sign-rule overflow.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [16:0] full;
        logic [15:0] mask, s;
        logic c, sa, sb, ss, v;
        mask = 16'((17'd1 << w) - 17'd1);
        if (sub) full = {1'b0, a} - {1'b0, b} - 17'(cin);
        else     full = {1'b0, a} + {1'b0, b} + 17'(cin);
        s  = full[15:0] & mask;
        c  = full[w];
        sa = a[w-1];
        sb = b[w-1];
        ss = s[w-1];
        v  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {s, c, v};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && if16.DONE) begin
            if (exp16_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL d16_unexpected_done: got sum=%h, expected no result", if16.SUM);
            end else begin
                e16 = exp16_q.pop_front();
                check("d16_result", 32'({if16.SUM, if16.CARRY, if16.OVF}), 32'(e16));
                check("d16_busy_in_fin", 32'(if16.BUSY), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if81.DONE) begin
            if (exp81_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL d81_unexpected_done: got sum=%h, expected no result", if81.SUM);
            end else begin
                e81 = exp81_q.pop_front();
                check("d81_result", 32'({if81.SUM, if81.CARRY, if81.OVF}), 32'(e81));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if88.DONE) begin
            if (exp88_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL d88_unexpected_done: got sum=%h, expected no result", if88.SUM);
            end else begin
                e88 = exp88_q.pop_front();
                check("d88_result", 32'({if88.SUM, if88.CARRY, if88.OVF}), 32'(e88));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge with the DUT idle or in FIN; returns on the DONE negedge.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [17:0] exp, input string name);
        int lat, busy_n;
        if16.A = a; if16.B = b; if16.CIN = cin; if16.SUB = sub; if16.START = 1'b1;
        exp16_q.push_back(exp);
        lat = 0; busy_n = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                if16.START = 1'b0;
                if16.A = 16'($urandom); if16.B = 16'($urandom);
                if16.CIN = 1'($urandom); if16.SUB = 1'($urandom);
            end
            lat++;
            if (if16.DONE) break;
            if (if16.BUSY) busy_n++;
        end
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd4);
    endtask

    task automatic run8(input bit sel88, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [9:0] exp, input string name);
        int lat, busy_n, exp_lat;
        exp_lat = sel88 ? 2 : 9;
        if (sel88) begin
            if88.A = a; if88.B = b; if88.CIN = cin; if88.SUB = sub; if88.START = 1'b1;
            exp88_q.push_back(exp);
        end else begin
            if81.A = a; if81.B = b; if81.CIN = cin; if81.SUB = sub; if81.START = 1'b1;
            exp81_q.push_back(exp);
        end
        lat = 0; busy_n = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                if88.START = 1'b0; if81.START = 1'b0;
                if88.A = 8'($urandom); if88.B = 8'($urandom);
                if81.A = 8'($urandom); if81.B = 8'($urandom);
            end
            lat++;
            if (sel88 ? if88.DONE : if81.DONE) break;
            if (sel88 ? if88.BUSY : if81.BUSY) busy_n++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int done_n;
        logic [7:0] ra, rb;
        logic rc, rs;
        logic [17:0] m;

        if16.START = 1'b0; if16.A = '0; if16.B = '0; if16.CIN = 1'b0; if16.SUB = 1'b0;
        if81.START = 1'b0; if81.A = '0; if81.B = '0; if81.CIN = 1'b0; if81.SUB = 1'b0;
        if88.START = 1'b0; if88.A = '0; if88.B = '0; if88.CIN = 1'b0; if88.SUB = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  32'(if16.BUSY),  32'd0);
        check("rst_done",  32'(if16.DONE),  32'd0);
        check("rst_sum",   32'(if16.SUM),   32'd0);
        check("rst_carry", 32'(if16.CARRY), 32'd0);
        check("rst_ovf",   32'(if16.OVF),   32'd0);
        check("rst_state", 32'(if16.STATE), 32'(ST_IDLE));
        check("rst_sum81", 32'(if81.SUM),   32'd0);
        check("rst_busy88", 32'(if88.BUSY), 32'd0);

        // Directed 16/4 vectors; later ones start in FIN (back-to-back).
        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, {16'h2233, 1'b0, 1'b0}, "add_basic");
        @(negedge clk);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}, "add_wrap");
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, "add_ovf");
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b1, 1'b0}, "sub_borrow");
        run16(16'h0010, 16'h0003, 1'b1, 1'b1, {16'h000C, 1'b0, 1'b0}, "sub_cin");

        // Result holds after FIN.
        repeat (3) @(negedge clk);
        check("hold_sum",   32'(if16.SUM),   32'h000C);
        check("hold_carry", 32'(if16.CARRY), 32'd0);
        check("hold_done",  32'(if16.DONE),  32'd0);
        check("hold_state", 32'(if16.STATE), 32'(ST_IDLE));

        // START during RUN is ignored; START during FIN is accepted.
        if16.A = 16'h1111; if16.B = 16'h2222; if16.CIN = 1'b0; if16.SUB = 1'b0; if16.START = 1'b1;
        exp16_q.push_back({16'h3333, 1'b0, 1'b0});
        @(negedge clk);
        if16.START = 1'b0;
        @(negedge clk);
        if16.A = 16'hAAAA; if16.B = 16'h5555; if16.SUB = 1'b1; if16.START = 1'b1;
        @(negedge clk);
        if16.START = 1'b0;
        n = 0;
        while (!if16.DONE && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hs_first_done_delay", 32'(n), 32'd2);
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1}, "b2b_sub");

        // Reset mid-operation aborts and clears results.
        @(negedge clk);
        if16.A = 16'h0100; if16.B = 16'h0200; if16.CIN = 1'b0; if16.SUB = 1'b0; if16.START = 1'b1;
        @(negedge clk);
        if16.START = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  32'(if16.BUSY),  32'd0);
        check("abort_done",  32'(if16.DONE),  32'd0);
        check("abort_sum",   32'(if16.SUM),   32'd0);
        check("abort_carry", 32'(if16.CARRY), 32'd0);
        check("abort_ovf",   32'(if16.OVF),   32'd0);
        check("abort_state", 32'(if16.STATE), 32'(ST_IDLE));
        rst = 1'b0;
        done_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (if16.DONE) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);

        // Digit extremes: 8/1 (eight digits) and 8/8 (single digit).
        run8(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1}, "d81_sub_ovf");
        run8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0}, "d81_add_wrap");
        run8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1}, "d88_sub_ovf");
        run8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}, "d88_add_ovf");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));   rs = 1'($urandom_range(0, 1));
            m = model(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
            run8(1'b0, ra, rb, rc, rs, m[9:0], "d81_rand");
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));   rs = 1'($urandom_range(0, 1));
            m = model(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
            run8(1'b1, ra, rb, rc, rs, m[9:0], "d88_rand");
        end

        repeat (3) @(negedge clk);
        check("pending16", 32'(exp16_q.size()), 32'd0);
        check("pending81", 32'(exp81_q.size()), 32'd0);
        check("pending88", 32'(exp88_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
